// File: rtl/audio_rate_decimator.sv
// audio_rate_decimator: IIR low-pass, NCO decimation to RATE_HZ, gain/saturation/volume, valid/ready + toggle output.
//   Optional macro AUDIO_DCBLOCK_EN inserts a one-pole DC blocker on the decimated stream.
//   clk, resetn (async, active-low); audio_l/audio_r signed IN_W inputs; volume 0 mute..3 unity;
//   out_l/out_r signed OUT_W pair, out_valid/out_ready handshake, out_tgl per new pair, overrun sticky.
module audio_rate_decimator #(
    parameter int CLK_HZ  = 31500000,
    parameter int RATE_HZ = 48000,
    parameter int IN_W    = 18,
    parameter int OUT_W   = 16,
    parameter int K       = 6,
    parameter int GAIN_SH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [IN_W-1:0]  audio_l,
    input  logic [IN_W-1:0]  audio_r,
    input  logic [1:0]       volume,
    output logic [OUT_W-1:0] out_l,
    output logic [OUT_W-1:0] out_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_tgl,
    output logic             overrun
);
    localparam int PW = $clog2(CLK_HZ) + 1;
    localparam int SW = IN_W + K;
    localparam int SH = IN_W - OUT_W - GAIN_SH;
    localparam logic [PW-1:0] INC = PW'(RATE_HZ);
    localparam logic [PW-1:0] MOD = PW'(CLK_HZ);

    function automatic logic [SW-1:0] iir_next(input logic [SW-1:0] s, input logic [IN_W-1:0] x);
        logic signed [SW:0] d;
        logic signed [SW:0] q;
        // one extra bit so (x<<K) - s cannot overflow before the shift
        d = {x[IN_W-1], x, {K{1'b0}}} - {s[SW-1], s};
        q = d >>> K;
        return s + q[SW-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] post(input logic [IN_W-1:0] f, input logic [1:0] vol);
        logic signed [IN_W-1:0] v;
        logic signed [OUT_W-1:0] c, q1, q2;
        v = $signed(f) >>> SH;
        c = (&v[IN_W-1:OUT_W-1] | ~|v[IN_W-1:OUT_W-1]) ? v[OUT_W-1:0]
            : {v[IN_W-1], {(OUT_W-1){~v[IN_W-1]}}};
        q1 = c >>> 1;
        q2 = c >>> 2;
        return vol == 2'd0 ? '0 : vol == 2'd1 ? q2 : vol == 2'd2 ? q1 : c;
    endfunction

    logic [PW-1:0]   phase, sum;
    logic            tick;
    logic [SW-1:0]   s_l, s_r;
    logic [IN_W-1:0] f_l, f_r, g_l, g_r, p1_l, p1_r;
    logic            p1_v;

    always_comb begin
        sum  = phase + INC;
        tick = sum >= MOD;
        f_l  = s_l[SW-1:K];
        f_r  = s_r[SW-1:K];
    end

`ifdef AUDIO_DCBLOCK_EN
    function automatic logic [IN_W+1:0] dc_y(input logic [IN_W-1:0] f, input logic [IN_W-1:0] fp,
                                             input logic [IN_W+1:0] yp);
        logic [IN_W+2:0] d;
        // yp[IN_W+1:8] with sign fill is yp >>> 8
        d = {{3{f[IN_W-1]}}, f} - {{3{fp[IN_W-1]}}, fp} + {yp[IN_W+1], yp}
            - {{9{yp[IN_W+1]}}, yp[IN_W+1:8]};
        return (d[IN_W+2] == d[IN_W+1]) ? d[IN_W+1:0] : {d[IN_W+2], {(IN_W+1){~d[IN_W+2]}}};
    endfunction

    function automatic logic [IN_W-1:0] sat_in(input logic [IN_W+1:0] y);
        return (&y[IN_W+1:IN_W-1] | ~|y[IN_W+1:IN_W-1]) ? y[IN_W-1:0]
               : {y[IN_W+1], {(IN_W-1){~y[IN_W+1]}}};
    endfunction

    logic [IN_W-1:0] fp_l, fp_r;
    logic [IN_W+1:0] yp_l, yp_r, yn_l, yn_r;

    always_comb begin
        yn_l = dc_y(f_l, fp_l, yp_l);
        yn_r = dc_y(f_r, fp_r, yp_r);
        g_l  = sat_in(yn_l);
        g_r  = sat_in(yn_r);
    end

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            fp_l <= '0;
            fp_r <= '0;
            yp_l <= '0;
            yp_r <= '0;
        end else if (tick) begin
            fp_l <= f_l;
            fp_r <= f_r;
            yp_l <= yn_l;
            yp_r <= yn_r;
        end
`else
    always_comb begin
        g_l = f_l;
        g_r = f_r;
    end
`endif

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            phase     <= '0;
            s_l       <= '0;
            s_r       <= '0;
            p1_v      <= 1'b0;
            p1_l      <= '0;
            p1_r      <= '0;
            out_l     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
            out_tgl   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            phase <= tick ? sum - MOD : sum;
            s_l   <= iir_next(s_l, audio_l);
            s_r   <= iir_next(s_r, audio_r);
            p1_v  <= tick;
            if (tick) begin
                p1_l <= g_l;
                p1_r <= g_r;
            end
            // a new pair always wins; losing an unaccepted one is flagged
            if (p1_v) begin
                out_l     <= post(p1_l, volume);
                out_r     <= post(p1_r, volume);
                out_valid <= 1'b1;
                out_tgl   <= ~out_tgl;
                if (out_valid && !out_ready)
                    overrun <= 1'b1;
            end else if (out_ready)
                out_valid <= 1'b0;
        end
endmodule

// File: tb/tb_audio_rate_decimator.sv
// tb_audio_rate_decimator: random-stimulus bench comparing audio_rate_decimator against an arithmetic reference model.
module tb_audio_rate_decimator;
    localparam longint CLK_HZ  = 31500000;
    localparam longint RATE_HZ = 48000;

    logic        clk = 1'b0;
    logic        resetn;
    logic [17:0] audio_l = '0, audio_r = '0;
    logic [1:0]  volume = 2'd3;
    logic        out_ready = 1'b1;
    logic [15:0] out_l, out_r;
    logic        out_valid, out_tgl, overrun;

    int total = 0, bad = 0;

    audio_rate_decimator dut (
        .clk(clk), .resetn(resetn), .audio_l(audio_l), .audio_r(audio_r), .volume(volume),
        .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .out_ready(out_ready),
        .out_tgl(out_tgl), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        return v > hi ? hi : v < lo ? lo : v;
    endfunction

    // output stage: gain shift of 1, clamp to 16 bits, volume as arithmetic divide-by-power-of-two
    function automatic longint post_m(input longint f, input int vol);
        longint v;
        v = clamp(f >>> 1, -32768, 32767);
        return vol == 0 ? 0 : vol == 1 ? v >>> 2 : vol == 2 ? v >>> 1 : v;
    endfunction

    // reference model state
    longint n, sl, sr, p1l, p1r, el, er;
    bit     p1v, ev, et, eo;
`ifdef AUDIO_DCBLOCK_EN
    longint fpl, fpr, ypl, ypr;
`endif

    always @(posedge clk or negedge resetn) begin
        longint fl, fr, gl, gr;
        bit tk;
        if (!resetn) begin
            n = 0; sl = 0; sr = 0; p1l = 0; p1r = 0; el = 0; er = 0;
            p1v = 0; ev = 0; et = 0; eo = 0;
`ifdef AUDIO_DCBLOCK_EN
            fpl = 0; fpr = 0; ypl = 0; ypr = 0;
`endif
        end else begin
            // a tick happens whenever n*RATE/CLK crosses an integer
            tk = ((n + 1) * RATE_HZ) / CLK_HZ != (n * RATE_HZ) / CLK_HZ;
            n++;
            if (p1v) begin
                if (ev && !out_ready) eo = 1;
                ev = 1;
                et = ~et;
                el = post_m(p1l, volume);
                er = post_m(p1r, volume);
            end else if (out_ready) ev = 0;
            fl = sl >>> 6;
            fr = sr >>> 6;
            sl = sl + (((longint'($signed(audio_l)) * 64) - sl) >>> 6);
            sr = sr + (((longint'($signed(audio_r)) * 64) - sr) >>> 6);
            gl = fl;
            gr = fr;
`ifdef AUDIO_DCBLOCK_EN
            if (tk) begin
                longint yl, yr;
                yl = clamp(fl - fpl + ypl - (ypl >>> 8), -(64'sd1 <<< 19), (64'sd1 <<< 19) - 1);
                yr = clamp(fr - fpr + ypr - (ypr >>> 8), -(64'sd1 <<< 19), (64'sd1 <<< 19) - 1);
                fpl = fl; fpr = fr; ypl = yl; ypr = yr;
                gl = clamp(yl, -131072, 131071);
                gr = clamp(yr, -131072, 131071);
            end
`endif
            p1v = tk;
            if (tk) begin
                p1l = gl;
                p1r = gr;
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        chk("out_valid", out_valid, ev);
        chk("out_tgl", out_tgl, et);
        chk("overrun", overrun, eo);
        chk("out_l", $signed(out_l), el);
        chk("out_r", $signed(out_r), er);
    end

    // toggle spacing must be floor/ceil of CLK_HZ/RATE_HZ
    longint cyc = 0, last = -1;
    bit     prev_t = 0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (!resetn) begin
            last = -1;
            prev_t = 0;
        end else if (out_tgl != prev_t) begin
            if (last >= 0) chk("tgl_gap_656_657", int'(cyc - last == 656 || cyc - last == 657), 1);
            last = cyc;
            prev_t = out_tgl;
        end
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
        #1;
    endtask

    task automatic wait_tgl(input string name);
        bit t0, seen;
        t0 = out_tgl;
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            seen = out_tgl != t0;
        end
        if (!seen) chk({name, "_timeout"}, 0, 1);
        #1;
    endtask

    initial begin
        int cnt;
        int vols[4] = '{3, 2, 1, 0};
        int want[4] = '{8192, 4096, 2048, 0};
        resetn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            audio_l = 18'($urandom);
            audio_r = 18'($urandom);
            volume  = 2'($urandom);
        end
        chk("reset_out_l", out_l, 0);
        chk("reset_out_r", out_r, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_tgl", out_tgl, 0);
        chk("reset_overrun", overrun, 0);

        volume = 2'd3;
        resetn = 1'b1;
        cnt = 0;
        while (cnt < 2000) begin
            @(negedge clk);
            cnt++;
            if (out_valid) break;
            #1;
            audio_l = 18'($urandom);
            audio_r = 18'($urandom);
        end
        chk("first_valid_latency", cnt, 658);
        #1;

        audio_l = 18'h1FFFF;
        audio_r = 18'h20000;
        step(3000);
`ifndef AUDIO_DCBLOCK_EN
        chk("sat_pos", out_l, 16'h7FFF);
        chk("sat_neg", out_r, 16'h8000);
`endif

        audio_l = 18'h04000;
        audio_r = 18'h3F000;
        step(3000);
        for (int i = 0; i < 4; i++) begin
            volume = 2'(vols[i]);
            wait_tgl("vol");
`ifndef AUDIO_DCBLOCK_EN
            chk($sformatf("vol%0d", vols[i]), $signed(out_l), want[i]);
`endif
        end

        volume = 2'd3;
        step(1);
        chk("overrun_before", overrun, 0);
        out_ready = 1'b0;
        wait_tgl("hs1");
        wait_tgl("hs2");
        step(3);
        chk("hs_valid_held", out_valid, 1);
        chk("hs_overrun", overrun, 1);
`ifndef AUDIO_DCBLOCK_EN
        chk("hs_second_sample", $signed(out_l), 8192);
`endif
        out_ready = 1'b1;
        step(1);
        chk("hs_valid_drop", out_valid, 0);

        for (int r = 0; r < 3; r++) begin
            resetn = 1'b0;
            step(3);
            resetn = 1'b1;
            for (int i = 0; i < 7000; i++) begin
                audio_l = ($urandom_range(0, 3) == 0) ? 18'($urandom) : audio_l;
                audio_r = ($urandom_range(0, 3) == 0) ? 18'($urandom) : audio_r;
                if ($urandom_range(0, 199) == 0) volume = 2'($urandom);
                out_ready = ($urandom_range(0, 9) != 0);
                step(1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
